mrv1_sys_fu: RTL

MRV1_SYS_FU -- requirements
Module: mrv1_sys_fu

---
 rtl/mrv1_sys_fu.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/mrv1_sys_fu.sv
`default_nettype none
// ============================================================================
// Module   : mrv1_sys_fu
// Brief    : System unit: CSR access (mscratch, cycle, cycleh, mhartid) and
//            thread spawn, one request in flight. Optional MRV_SYS_FU_TSPAWN_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mrv1_sys_fu #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int HART_ID    = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [6:0]            req_op_i,
    input  logic [11:0]           req_csr_addr_i,
    input  logic [DATA_WIDTH-1:0] req_src_i,
    input  logic [TAG_WIDTH-1:0]  req_tag_i,
    output logic                  wb_valid_o,
    input  logic                  wb_ready_i,
    output logic [TAG_WIDTH-1:0]  wb_tag_o,
    output logic [DATA_WIDTH-1:0] wb_data_o,
    output logic                  wb_err_o,
    output logic                  spawn_valid_o,
    input  logic                  spawn_ready_i,
    output logic [DATA_WIDTH-1:0] spawn_pc_o,
    input  logic [DATA_WIDTH-1:0] spawn_tid_i
);

    localparam logic [6:0]  OP_CSR_READ  = 7'h00;
    localparam logic [6:0]  OP_CSR_WRITE = 7'h01;
    localparam logic [6:0]  OP_CSR_SET   = 7'h02;
    localparam logic [6:0]  OP_CSR_CLR   = 7'h03;
    localparam logic [6:0]  OP_TSPAWN    = 7'h04;

    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPAWN = 2'd1,
        ST_WB    = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic [TAG_WIDTH-1:0]    tag_q, tag_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    err_q, err_d;
    logic [DATA_WIDTH-1:0]   mscratch_q, mscratch_d;
    logic [63:0]             cycle_q;

    logic                    csr_hit;
    logic                    csr_ro;
    logic [DATA_WIDTH-1:0]   csr_old;
    logic                    is_csr_op;
    logic                    csr_wr;
    logic [DATA_WIDTH-1:0]   csr_new;

    always_comb begin
        csr_old = '0;
        csr_hit = 1'b1;
        csr_ro  = 1'b1;
        case (req_csr_addr_i)
            CSR_MSCRATCH: begin
                csr_old = mscratch_q;
                csr_ro  = 1'b0;
            end
            CSR_CYCLE:   csr_old = DATA_WIDTH'(cycle_q[31:0]);
            CSR_CYCLEH:  csr_old = DATA_WIDTH'(cycle_q[63:32]);
            CSR_MHARTID: csr_old = DATA_WIDTH'(HART_ID);
            default:     csr_hit = 1'b0;
        endcase
    end

    // SET/CLR with a zero mask are pure reads, so they never fault on RO CSRs.
    assign is_csr_op = (req_op_i <= OP_CSR_CLR);
    assign csr_wr    = (req_op_i == OP_CSR_WRITE) ||
                       (((req_op_i == OP_CSR_SET) || (req_op_i == OP_CSR_CLR)) &&
                        (req_src_i != '0));

    always_comb begin
        csr_new = mscratch_q;
        case (req_op_i)
            OP_CSR_WRITE: csr_new = req_src_i;
            OP_CSR_SET:   csr_new = mscratch_q | req_src_i;
            OP_CSR_CLR:   csr_new = mscratch_q & ~req_src_i;
            default:      csr_new = mscratch_q;
        endcase
    end

`ifdef MRV_SYS_FU_TSPAWN_EN
    logic [DATA_WIDTH-1:0]   pc_q, pc_d;
`else
    logic                    unused_spawn;
    assign unused_spawn = spawn_ready_i ^ (^spawn_tid_i);
`endif

    always_comb begin
        state_d    = state_q;
        tag_d      = tag_q;
        data_d     = data_q;
        err_d      = err_q;
        mscratch_d = mscratch_q;
`ifdef MRV_SYS_FU_TSPAWN_EN
        pc_d       = pc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    tag_d   = req_tag_i;
                    state_d = ST_WB;
                    data_d  = '0;
                    err_d   = 1'b1;
                    if (is_csr_op && csr_hit) begin
                        data_d = csr_old;
                        err_d  = csr_wr && csr_ro;
                        if (csr_wr && !csr_ro) begin
                            mscratch_d = csr_new;
                        end
                    end
`ifdef MRV_SYS_FU_TSPAWN_EN
                    else if (req_op_i == OP_TSPAWN) begin
                        state_d = ST_SPAWN;
                        pc_d    = req_src_i;
                        err_d   = 1'b0;
                    end
`endif
                end
            end
            ST_SPAWN: begin
`ifdef MRV_SYS_FU_TSPAWN_EN
                if (spawn_ready_i) begin
                    state_d = ST_WB;
                    data_d  = spawn_tid_i;
                    err_d   = 1'b0;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_WB: begin
                if (wb_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            mscratch_q <= '0;
            cycle_q    <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            data_q     <= data_d;
            err_q      <= err_d;
            mscratch_q <= mscratch_d;
            cycle_q    <= cycle_q + 64'd1;
        end
    end

`ifdef MRV_SYS_FU_TSPAWN_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign spawn_valid_o = (state_q == ST_SPAWN);
    assign spawn_pc_o    = pc_q;
`else
    assign spawn_valid_o = 1'b0;
    assign spawn_pc_o    = '0;
`endif

    // Valids decode straight from state so both can never be high together.
    assign req_ready_o = (state_q == ST_IDLE);
    assign wb_valid_o  = (state_q == ST_WB);
    assign wb_tag_o    = tag_q;
    assign wb_data_o   = data_q;
    assign wb_err_o    = err_q;

endmodule
`default_nettype wire
